// File: rtl/tankwar_pkg.sv
// Shared PS/2 keyboard definitions: scan codes, ASCII codes, frame FSM states
// and the scan-code-to-ASCII lookup used by the key decoder.
package tankwar_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Set-2 make codes, non-extended
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    // Set-2 make codes, extended (arrow keys)
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [7:0] ASCII_W     = 8'h77;
    localparam logic [7:0] ASCII_A     = 8'h61;
    localparam logic [7:0] ASCII_S     = 8'h73;
    localparam logic [7:0] ASCII_D     = 8'h64;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_DATA,
        FR_PARITY,
        FR_STOP
    } frame_state_e;

    typedef struct packed {
        logic       hit;
        logic [7:0] ascii;
    } key_map_t;

    function automatic key_map_t map_scan(input logic ext, input logic [7:0] code);
        key_map_t m;
        m.hit   = 1'b1;
        m.ascii = 8'h00;
        if (ext) begin
            case (code)
                SC_UP:    m.ascii = ASCII_W;
                SC_LEFT:  m.ascii = ASCII_A;
                SC_DOWN:  m.ascii = ASCII_S;
                SC_RIGHT: m.ascii = ASCII_D;
                default:  m.hit   = 1'b0;
            endcase
        end else begin
            case (code)
                SC_W:     m.ascii = ASCII_W;
                SC_A:     m.ascii = ASCII_A;
                SC_S:     m.ascii = ASCII_S;
                SC_D:     m.ascii = ASCII_D;
                SC_SPACE: m.ascii = ASCII_SPACE;
                SC_ENTER: m.ascii = ASCII_CR;
                default:  m.hit   = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchroniser, falling-edge detect, 11-bit frame FSM
// and inactivity timeout. Odd parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx
    import tankwar_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk_100mhz,
    input  logic       RSTN,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frame_err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   prev_clk_q;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall;

    frame_state_e state_q, state_d;
    logic [2:0]   bitcnt_q, bitcnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic         byte_vld_q, byte_vld_d;
    logic         err_q, err_d;
    logic         par_ok;

    // Idle-high line: synchroniser resets to 1 so reset release never looks like an edge
    always_ff @(posedge clk_100mhz) begin
        if (!RSTN) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            prev_clk_q <= 1'b1;
        end else begin
            clk_sync_q[0] <= ps2_clk;
            dat_sync_q[0] <= ps2_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync_q[i] <= clk_sync_q[i-1];
                dat_sync_q[i] <= dat_sync_q[i-1];
            end
            prev_clk_q <= clk_s;
        end
    end

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall  = prev_clk_q & ~clk_s;

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok = ^{par_q, shift_q};
`else
    logic unused_par;
    assign unused_par = par_q;
    assign par_ok     = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = '0;
        byte_vld_d = 1'b0;
        err_d      = 1'b0;

        if (state_q != FR_IDLE && !fall)
            tmo_d = tmo_q + 1'b1;

        case (state_q)
            FR_IDLE: begin
                if (fall) begin
                    if (!dat_s) begin
                        state_d  = FR_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FR_DATA: begin
                if (fall) begin
                    shift_d  = {dat_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7)
                        state_d = FR_PARITY;
                end
            end
            FR_PARITY: begin
                if (fall) begin
                    par_d   = dat_s;
                    state_d = FR_STOP;
                end
            end
            FR_STOP: begin
                if (fall) begin
                    state_d = FR_IDLE;
                    if (dat_s && par_ok)
                        byte_vld_d = 1'b1;
                    else
                        err_d = 1'b1;
                end
            end
            default: state_d = FR_IDLE;
        endcase

        // A stalled keyboard drops the partial frame silently
        if (state_q != FR_IDLE && !fall && tmo_q == TMO_LAST) begin
            state_d = FR_IDLE;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!RSTN) begin
            state_q    <= FR_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            byte_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            byte_vld_q <= byte_vld_d;
            err_q      <= err_d;
        end
    end

    assign byte_o      = shift_q;
    assign byte_vld_o  = byte_vld_q;
    assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: E0/F0 prefix tracking and scan-code-to-ASCII mapping on
// top of ps2_frame_rx. PS2_PARITY_CHECK_EN enables odd-parity rejection in the receiver.
module ps2_key_decoder
    import tankwar_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk_100mhz,
    input  logic       RSTN,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic       press,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_vld;
    logic       rx_err;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .clk_100mhz  (clk_100mhz),
        .RSTN        (RSTN),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .byte_o      (rx_byte),
        .byte_vld_o  (rx_vld),
        .frame_err_o (rx_err)
    );

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [7:0] ascii_q, ascii_d;
    logic       press_q, press_d;
    logic       kv_q, kv_d;
    key_map_t   km;

    assign km = map_scan(ext_q, rx_byte);

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        ascii_d = ascii_q;
        press_d = press_q;
        kv_d    = 1'b0;

        if (rx_vld) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BREAK) begin
                brk_d = 1'b1;
            end else begin
                // Prefixes apply to exactly one code, mapped or not
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (km.hit) begin
                    ascii_d = km.ascii;
                    press_d = ~brk_q;
                    kv_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!RSTN) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            ascii_q <= 8'h00;
            press_q <= 1'b0;
            kv_q    <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            ascii_q <= ascii_d;
            press_q <= press_d;
            kv_q    <= kv_d;
        end
    end

    assign ascii     = ascii_q;
    assign press     = press_q;
    assign key_valid = kv_q;
    assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: bit-banged PS/2 frames, expected key events
// queued at stimulus time and popped on each key_valid pulse.
module tb_ps2_key_decoder;

    localparam int TMO  = 300;
    localparam int SYNC = 2;
    localparam int HALF = 10;

    logic       clk_100mhz = 1'b0;
    logic       RSTN       = 1'b0;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic [7:0] ascii;
    logic       press;
    logic       key_valid;
    logic       frame_err;

    always #5 clk_100mhz = ~clk_100mhz;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .RSTN       (RSTN),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ascii      (ascii),
        .press      (press),
        .key_valid  (key_valid),
        .frame_err  (frame_err)
    );

    typedef struct packed {
        logic [7:0] ascii;
        logic       press;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         stop_cyc = 0;
    int         err_seen = 0;
    int         exp_err = 0;
    logic [7:0] last_ascii = 8'h00;
    logic       last_press = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk_100mhz) cyc <= cyc + 1;

    always @(negedge clk_100mhz) begin
        exp_t e;
        if (frame_err) err_seen++;
        if (key_valid) begin
            chk("kv_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("kv_ascii", 32'(ascii), 32'(e.ascii));
                chk("kv_press", 32'(press), 32'(e.press));
                chk("kv_latency", 32'(cyc - stop_cyc), 32'(SYNC + 2));
            end
        end
    end

    function automatic logic [10:0] frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_100mhz);
            ps2_data = b[i];
            repeat (HALF) @(negedge clk_100mhz);
            ps2_clk = 1'b0;
            if (i == n - 1) stop_cyc = cyc;
            repeat (HALF) @(negedge clk_100mhz);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(frame(d), 11);
        repeat (20) @(negedge clk_100mhz);
    endtask

    task automatic expect_key(input logic [7:0] a, input logic p);
        exp_t e;
        e.ascii = a;
        e.press = p;
        exp_q.push_back(e);
        last_ascii = a;
        last_press = p;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN = 1'b0;
        repeat (5) @(negedge clk_100mhz);
        chk("rst_ascii", 32'(ascii), 0);
        chk("rst_press", 32'(press), 0);
        chk("rst_kv", 32'(key_valid), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        RSTN = 1'b1;
        repeat (10) @(negedge clk_100mhz);

        // Make, break, extended make/break
        expect_key(8'h77, 1'b1); send_byte(8'h1D);
        send_byte(8'hF0);
        expect_key(8'h77, 1'b0); send_byte(8'h1D);
        send_byte(8'hE0);
        expect_key(8'h61, 1'b1); send_byte(8'h6B);
        send_byte(8'hE0); send_byte(8'hF0);
        expect_key(8'h61, 1'b0); send_byte(8'h6B);

        // Typematic repeat then release
        expect_key(8'h77, 1'b1); send_byte(8'h1D);
        expect_key(8'h77, 1'b1); send_byte(8'h1D);
        send_byte(8'hF0);
        expect_key(8'h77, 1'b0); send_byte(8'h1D);

        // Remaining arrows and 's'
        send_byte(8'hE0); expect_key(8'h77, 1'b1); send_byte(8'h75);
        send_byte(8'hE0); expect_key(8'h73, 1'b1); send_byte(8'h72);
        send_byte(8'hE0); expect_key(8'h64, 1'b1); send_byte(8'h74);
        expect_key(8'h73, 1'b1); send_byte(8'h1B);

        // Unmapped code leaves outputs alone
        send_byte(8'h15);
        chk("unmapped_ascii", 32'(ascii), 32'(last_ascii));
        chk("unmapped_press", 32'(press), 32'(last_press));

        // Bad parity
`ifdef PS2_PARITY_CHECK_EN
        exp_err++;
`else
        expect_key(8'h61, 1'b1);
`endif
        send_bits(frame(8'h1C) ^ 11'h200, 11);
        repeat (20) @(negedge clk_100mhz);
        chk("badpar_err", 32'(err_seen), 32'(exp_err));
        chk("badpar_ascii", 32'(ascii), 32'(last_ascii));

        // Start bit of 1
        exp_err++;
        send_bits(11'h001, 1);
        repeat (20) @(negedge clk_100mhz);
        chk("badstart_err", 32'(err_seen), 32'(exp_err));

        // Stop bit of 0
        exp_err++;
        send_bits(frame(8'h1D) & ~11'h400, 11);
        repeat (20) @(negedge clk_100mhz);
        chk("badstop_err", 32'(err_seen), 32'(exp_err));
        chk("badstop_ascii", 32'(ascii), 32'(last_ascii));

        // Partial frame abandoned by timeout, then a clean frame
        send_bits(frame(8'h23), 5);
        repeat (TMO + 50) @(negedge clk_100mhz);
        chk("tmo_no_err", 32'(err_seen), 32'(exp_err));
        expect_key(8'h64, 1'b1); send_byte(8'h23);
        chk("tmo_ascii", 32'(ascii), 32'h64);
        chk("tmo_err_after", 32'(err_seen), 32'(exp_err));

        // Reset in the middle of a frame
        send_bits(frame(8'h29), 5);
        @(negedge clk_100mhz);
        RSTN = 1'b0;
        repeat (3) @(negedge clk_100mhz);
        chk("midrst_ascii", 32'(ascii), 0);
        chk("midrst_press", 32'(press), 0);
        RSTN = 1'b1;
        last_ascii = 8'h00;
        last_press = 1'b0;
        repeat (10) @(negedge clk_100mhz);
        expect_key(8'h0D, 1'b1); send_byte(8'h5A);
        chk("midrst_enter", 32'(ascii), 32'h0D);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_100mhz);
        chk("queue_drained", 32'(exp_q.size()), 0);
        chk("err_total", 32'(err_seen), 32'(exp_err));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
